// File: rtl/bubble_sort_seq.sv
// bubble_sort_seq: serial-in / serial-out frame sorter (ascending order).
// A frame of DATA_N unsigned elements is loaded over a valid/ready stream,
// sorted in place by DATA_N odd-even transposition passes (one pass per
// cycle), then drained smallest-first over a second valid/ready stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data carries one element
//   out_valid/out_ready  output handshake, out_data carries one element
//   out_last             marks the DATA_N-th (largest) output element
//   busy                 high while sorting or draining
module bubble_sort_seq #(
  parameter int unsigned DATA_N = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_N + 1);
  localparam int unsigned IDX_W = $clog2(DATA_N);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rd;
  logic [DATA_W-1:0] mem    [DATA_N];
  logic [DATA_W-1:0] pass_c [DATA_N];

  // One transposition pass: pairs starting at indices whose parity matches
  // the pass number. Pairs are disjoint, so every swap reads original values.
  // An unpaired element at either edge simply keeps its value.
  always_comb begin
    pass_c = mem;
    for (int i = 0; i < int'(DATA_N) - 1; i++) begin
      if ((i[0] == cnt[0]) && (mem[i] > mem[i+1])) begin
        pass_c[i]   = mem[i+1];
        pass_c[i+1] = mem[i];
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      cnt       <= '0;
      rd        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(DATA_N); i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid && in_ready) begin
            mem[IDX_W'(cnt)] <= in_data;
            if (cnt == CNT_W'(DATA_N - 1)) begin
              cnt      <= '0;
              state    <= S_SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_SORT: begin
          mem <= pass_c;
          if (cnt == CNT_W'(DATA_N - 1)) begin
            cnt   <= '0;
            rd    <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (!out_valid) begin
            // First drain cycle: present element rd.
            out_valid <= 1'b1;
            out_data  <= mem[IDX_W'(rd)];
            out_last  <= (rd == CNT_W'(DATA_N - 1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd        <= '0;
              state     <= S_LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              // Preload the next element so one beat moves per cycle.
              rd       <= rd + CNT_W'(1);
              out_data <= mem[IDX_W'(rd + CNT_W'(1))];
              out_last <= ((rd + CNT_W'(1)) == CNT_W'(DATA_N - 1));
            end
          end
        end

        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Self-checking bench for bubble_sort_seq (DATA_N=4, DATA_W=4).
module tb_bubble_sort_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  typedef logic [W-1:0] frame_t [N];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  bubble_sort_seq #(.DATA_N(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: repeatedly pick the smallest remaining element.
  function automatic frame_t ref_sort(input frame_t a);
    frame_t s;
    bit     used [N];
    for (int i = 0; i < int'(N); i++) used[i] = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      int best = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (!used[i] && (best < 0 || a[i] < a[best])) best = i;
      end
      used[best] = 1'b1;
      s[k] = a[best];
    end
    return s;
  endfunction

  // Feed one frame; optionally keep in_valid high with junk afterwards.
  task automatic load_frame(input frame_t f, input bit junk);
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      chk("in_ready_load", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = f[i];
      @(posedge clk);
    end
    #1;
    in_valid = junk;
    in_data  = junk ? 4'hF : 4'h0;
  endtask

  // Count edges after the last accept until out_valid is observed.
  task automatic wait_first();
    int lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        chk("sort_in_ready", 32'(in_ready), 32'd0);
        chk("sort_busy", 32'(busy), 32'd1);
      end
      if (in_valid) in_data = W'($urandom);
      if (out_valid) break;
    end
    chk("first_out_latency", 32'(lat), 32'(N + 1));
  endtask

  // Check each output beat; optionally stall stall_len cycles at beat stall_at.
  task automatic drain(input frame_t exp, input int stall_at, input int stall_len);
    for (int j = 0; j < int'(N); j++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(exp[j]));
      chk("out_last", 32'(out_last), 32'(j == int'(N) - 1));
      chk("in_ready_drain", 32'(in_ready), 32'd0);
      if (j == int'(N) - 1) in_valid = 1'b0;
      if (j == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk);
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(exp[j]));
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input frame_t f, input bit junk, input int stall_at, input int stall_len);
    load_frame(f, junk);
    wait_first();
    drain(ref_sort(f), stall_at, stall_len);
  endtask

  initial begin
    frame_t f;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    f = '{4'd3, 4'd1, 4'd2, 4'd0};
    run_frame(f, 1'b0, -1, 0);

    f = '{4'd5, 4'd5, 4'd1, 4'd5};
    run_frame(f, 1'b0, -1, 0);

    f = '{4'd15, 4'd14, 4'd13, 4'd12};
    run_frame(f, 1'b0, -1, 0);

    f = '{4'd3, 4'd1, 4'd2, 4'd0};
    run_frame(f, 1'b0, 1, 3);

    f = '{4'd9, 4'd8, 4'd7, 4'd6};
    run_frame(f, 1'b1, -1, 0);

    f = '{4'd9, 4'd8, 4'd7, 4'd6};
    run_frame(f, 1'b0, -1, 0);

    // Abort a frame with reset in the middle of the third sort pass.
    f = '{4'd7, 4'd3, 4'd9, 4'd1};
    load_frame(f, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_out_last", 32'(out_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_output", 32'(out_valid), 32'd0);
    end

    f = '{4'd4, 4'd0, 4'd4, 4'd0};
    run_frame(f, 1'b0, -1, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(N); i++) f[i] = W'($urandom);
      run_frame(f, r[0], int'($urandom_range(0, N)), int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
